// File: rtl/mw_stage.sv
// Memory-to-writeback pipeline register for the 5-stage MIPS core.
// Owns the data-bus handshake, stalls M until the access completes, and drives the regfile write port.
package mw_pkg;
    localparam int DW = 32;
    localparam int RW = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef struct packed {
        logic          valid;
        logic [31:0]   addr;
        logic [1:0]    size;
        logic [3:0]    strobe;
        logic [DW-1:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic          addr_ok;
        logic          data_ok;
        logic [DW-1:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic [3:0]    stat;
        logic [5:0]    opcode;
        logic [DW-1:0] val_e;
        logic [RW-1:0] dst_e;
        logic [RW-1:0] dst_m;
        logic [5:0]    funct;
        logic [31:0]   pc;
    } plr_w;
endpackage

module mw_stage
    import mw_pkg::*;
#(
    parameter int DATA_W = mw_pkg::DW,
    parameter int RA_W   = mw_pkg::RW
) (
    input  logic              clk,
    input  logic              reset,
    input  plr_w              m_w,
    input  dbus_req_t         m_dreq,
    output dbus_req_t         dreq,
    input  dbus_resp_t        dresp,
    output logic              mem_stall,
    output plr_w              w_q,
    output logic [DATA_W-1:0] w_valm,
    output logic              rf_we,
    output logic [RA_W-1:0]   rf_wa,
    output logic [DATA_W-1:0] rf_wd
);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_ADDR = 2'd1;
    localparam logic [1:0] S_WAIT_DATA = 2'd2;

    logic [1:0] state, state_nx;
    dbus_req_t  req_q;
    logic       ld_q;
    logic       complete;
    logic       cur_ld;

    always_comb begin
        state_nx = state;
        complete = 1'b0;
        cur_ld   = ld_q;
        dreq     = '0;
        case (state)
            S_IDLE: begin
                dreq   = m_dreq;
                cur_ld = m_dreq.valid && (m_dreq.strobe == 4'b0000);
                if (!m_dreq.valid)
                    complete = 1'b1;
                else if (dresp.addr_ok && dresp.data_ok)
                    complete = 1'b1;
                else if (dresp.addr_ok)
                    state_nx = S_WAIT_DATA;
                else
                    state_nx = S_WAIT_ADDR;
            end
            S_WAIT_ADDR: begin
                dreq       = req_q;
                dreq.valid = 1'b1;
                if (dresp.addr_ok && dresp.data_ok) begin
                    complete = 1'b1;
                    state_nx = S_IDLE;
                end else if (dresp.addr_ok) begin
                    state_nx = S_WAIT_DATA;
                end
            end
            S_WAIT_DATA: begin
                if (dresp.data_ok) begin
                    complete = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign mem_stall = ~complete;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            req_q  <= '0;
            ld_q   <= 1'b0;
            w_q    <= '0;
            w_valm <= '0;
        end else begin
            state <= state_nx;
            // Request fields are only replayed from req_q while the address phase is pending.
            if (state == S_IDLE && m_dreq.valid) begin
                ld_q <= (m_dreq.strobe == 4'b0000);
                if (!dresp.addr_ok)
                    req_q <= m_dreq;
            end
            if (complete) begin
                w_q <= m_w;
                if (cur_ld)
                    w_valm <= dresp.data;
            end else begin
                w_q <= '0;
            end
        end
    end

    // An all-zero bundle decodes as R-type with dst 0, so bubbles never write.
    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (w_q.opcode == OP_LW && w_q.dst_m != '0) begin
            rf_we = 1'b1;
            rf_wa = w_q.dst_m;
            rf_wd = w_valm;
        end else if ((w_q.opcode inside {OP_RTYPE, OP_LUI, OP_SLTI, OP_SLTIU, OP_ADDIU,
                                         OP_ANDI, OP_ORI, OP_XORI, OP_JAL})
                     && w_q.dst_e != '0) begin
            rf_we = 1'b1;
            rf_wa = w_q.dst_e;
            rf_wd = w_q.val_e;
        end
    end
endmodule

// File: doc/mw_stage.md
# mw_stage

Memory-to-writeback stage register for the 5-stage MIPS pipeline. It takes the combinational memory-stage outputs (the W-bound pipeline bundle and the data-bus request) and owns the data-bus handshake. It stalls the pipeline until the request completes, captures load data, and presents the registered W bundle plus the register-file write port.

## Interface
Parameters:
- DATA_W, 32, data-bus and register-file data width
- RA_W, 5, register-file address width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- m_w  in  plr_w  W-bound bundle from the memory stage (stat, opcode, valE, dstE, dstM, funct, pc)
- m_dreq  in  dbus_req_t  request from the memory stage; valid marks a LW/SW
- dreq  out  dbus_req_t  request driven to the data bus
- dresp  in  dbus_resp_t  bus response (addr_ok, data_ok, data)
- mem_stall  out  1  high while the current M instruction cannot retire; upstream holds M and younger stages
- w_q  out  plr_w  registered W bundle
- w_valm  out  DATA_W  registered load data
- rf_we  out  1  register-file write enable
- rf_wa  out  RA_W  register-file write address
- rf_wd  out  DATA_W  register-file write data

## Operation
- FSM states are IDLE, WAIT_ADDR and WAIT_DATA. Request registers are req_q (dbus_req_t) and ld_q (1 bit, set when the request is a load, strobe==0).
- IDLE:
  - dreq equals m_dreq.
  - If m_dreq.valid=0, the access completes trivially.
  - If valid, addr_ok=1 and data_ok=1: complete this cycle.
  - If valid, addr_ok=1 and data_ok=0: go to WAIT_DATA.
  - If valid and addr_ok=0: latch req_q from m_dreq and go to WAIT_ADDR.
- WAIT_ADDR:
  - dreq equals req_q with valid=1.
  - If addr_ok and data_ok: complete and return to IDLE.
  - If addr_ok only: go to WAIT_DATA.
  - Otherwise stay in WAIT_ADDR.
- WAIT_DATA:
  - dreq.valid=0 and the other dreq fields are don't-care.
  - If data_ok: complete and return to IDLE.
  - Otherwise stay in WAIT_DATA.
- mem_stall = ~complete, where complete is the completion condition above for the current state.
- On the edge where complete=1:
  - w_q <= m_w.
  - w_valm <= dresp.data for loads; otherwise w_valm holds its value.
- On a stall edge, insert a bubble into W:
  - w_q <= '0 (opcode 0, dstE=dstM=0).
  - w_valm is held.
- dreq.data, size and strobe are passed through unmodified. The block does not inspect the address.
- Writeback is combinational from the W registers:
  - If w_q.opcode==OP_LW and w_q.dstM!=0: rf_we=1, rf_wa=dstM, rf_wd=w_valm.
  - Else, if w_q.opcode is in {OP_RTYPE, OP_LUI, OP_SLTI, OP_SLTIU, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_JAL} and dstE!=0: rf_we=1, rf_wa=dstE, rf_wd=valE.
  - Else rf_we=0, rf_wa=0, rf_wd=0.
  - A write to register 0 is never enabled.
- Reset:
  - state=IDLE, req_q='0, w_q='0, w_valm=0.
  - As a result rf_we=0, and dreq.valid equals m_dreq.valid.
  - Reset during WAIT_ADDR or WAIT_DATA aborts the access. Any later data_ok is ignored because the block is in IDLE with no outstanding request.
- Simultaneous addr_ok and data_ok count as both handshakes in one cycle.
- data_ok while in IDLE with m_dreq.valid=0 is ignored.

## Timing
- Zero-wait access (addr_ok and data_ok in the request cycle): no stall. The result appears in w_q/w_valm on the next edge, and the regfile write occurs in that following cycle.
- Each cycle without addr_ok adds one stall cycle. Each cycle between addr_ok and data_ok adds one stall cycle.
- Total stall = number of cycles from the first request cycle up to, but not including, the completing cycle.
- dreq.valid stays asserted continuously from the first request cycle until addr_ok, and deasserts the cycle after addr_ok.
- At most one outstanding request.
- mem_stall is combinational in dresp. Upstream must not feed it back into dreq.valid.

## Test plan
- ADDIU $3 with valE=0x00000010 and no dreq: next cycle rf_we=1, rf_wa=3, rf_wd=0x10, mem_stall never high.
- LW $5 with addr_ok=data_ok=1 in the same cycle and data=0xDEADBEEF: no stall; next cycle rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF.
- LW $7 with addr_ok delayed 2 cycles, then data_ok 3 cycles after that, data=0x12345678:
  - mem_stall high for 5 cycles.
  - dreq.valid high for exactly 3 cycles.
  - W carries bubbles (rf_we=0) during the stall, then rf_wd=0x12345678.
- SW with strobe=4'b1111 and data=0xA5A5A5A5, addr_ok=1, data_ok one cycle later: 1 stall cycle, dreq.data=0xA5A5A5A5, rf_we=0 afterwards.
- reset asserted while in WAIT_DATA, with a stray data_ok the following cycle: state goes to IDLE, w_q=0, rf_we=0, and the stray data_ok causes no write.
- ORI with dstE=0: rf_we stays 0.
